// File: rtl/fft_frame_ctrl.sv
// Ping-pong input-bank fill controller and butterfly stage sequencer for the FFT front end.
// Samples land in one bank while the other bank's full frame is run through the stages.
module fft_frame_ctrl #(
  parameter int unsigned N         = 16,
  parameter int unsigned NPTS      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned STAGES    = 5,
  parameter int unsigned STAGE_CYC = 1
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [N-1:0]  in_data_i,
  output logic          in_ready_o,
  output logic          wr_en_o,
  output logic          wr_bank_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [N-1:0]  wr_data_o,
  output logic          stage_en_o,
  output logic [2:0]    stage_idx_o,
  output logic          calc_bank_o,
  output logic          frame_done_o,
  output logic          ovf_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned CW = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;

  localparam logic [AW-1:0] LastAddr  = AW'(NPTS - 1);
  localparam logic [CW-1:0] LastCyc   = CW'(STAGE_CYC - 1);
  localparam logic [2:0]    LastStage = 3'(STAGES - 1);

  logic [AW-1:0] fill_cnt_q, fill_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          calc_bank_q, calc_bank_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    stage_idx_q, stage_idx_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic          stage_en_q, stage_en_d;
  logic          frame_done_q, frame_done_d;
  logic          ovf_q, ovf_d;

  logic          ready;
  logic          accept;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  assign ready  = ~full_q[wr_bank_q];
  assign accept = in_valid_i & ready;

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    wr_bank_d  = wr_bank_q;
    full_set   = 2'b00;
    if (accept) begin
      if (fill_cnt_q == LastAddr) begin
        fill_cnt_d          = '0;
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end else begin
        fill_cnt_d = fill_cnt_q + AW'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_idx_d  = stage_idx_q;
    cyc_cnt_d    = cyc_cnt_q;
    stage_en_d   = 1'b0;
    frame_done_d = 1'b0;
    calc_bank_d  = calc_bank_q;
    full_clr     = 2'b00;
    case (state_q)
      StIdle: begin
        if (full_q[calc_bank_q]) begin
          state_d     = StRun;
          stage_idx_d = '0;
          cyc_cnt_d   = '0;
          stage_en_d  = 1'b1;
        end
      end
      StRun: begin
        stage_en_d = 1'b1;
        if (cyc_cnt_q == LastCyc) begin
          cyc_cnt_d = '0;
          if (stage_idx_q == LastStage) begin
            state_d      = StDone;
            stage_en_d   = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            stage_idx_d = stage_idx_q + 3'd1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
      end
      StDone: begin
        // Fill only ever sets a non-full bank, so this clear never collides with a set.
        full_clr[calc_bank_q] = 1'b1;
        calc_bank_d           = ~calc_bank_q;
        state_d               = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign full_d = (full_q | full_set) & ~full_clr;
  assign ovf_d  = ovf_q | (in_valid_i & ~ready);

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      fill_cnt_q   <= '0;
      wr_bank_q    <= 1'b0;
      calc_bank_q  <= 1'b0;
      full_q       <= 2'b00;
      state_q      <= StIdle;
      stage_idx_q  <= '0;
      cyc_cnt_q    <= '0;
      stage_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      wr_bank_q    <= wr_bank_d;
      calc_bank_q  <= calc_bank_d;
      full_q       <= full_d;
      state_q      <= state_d;
      stage_idx_q  <= stage_idx_d;
      cyc_cnt_q    <= cyc_cnt_d;
      stage_en_q   <= stage_en_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign in_ready_o   = ready;
  assign wr_en_o      = accept;
  assign wr_bank_o    = wr_bank_q;
  assign wr_addr_o    = fill_cnt_q;
  assign wr_data_o    = in_data_i;
  assign stage_en_o   = stage_en_q;
  assign stage_idx_o  = stage_idx_q;
  assign calc_bank_o  = calc_bank_q;
  assign frame_done_o = frame_done_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: three instances (STAGE_CYC 1, 20, 3) sharing clock and reset,
// write scoreboard on the default instance and a stage-timing model on all three.
module tb_fft_frame_ctrl;

  logic        clk2;
  logic        rst;
  logic        in_valid;
  logic        in_valid_s;
  logic [15:0] in_data;

  logic       in_ready, wr_en, wr_bank, stage_en, calc_bank, frame_done, ovf;
  logic [4:0] wr_addr;
  logic [15:0] wr_data;
  logic [2:0] stage_idx;

  logic       in_ready_s, wr_en_s, wr_bank_s, stage_en_s, calc_bank_s, frame_done_s, ovf_s;
  logic [4:0] wr_addr_s;
  logic [15:0] wr_data_s;
  logic [2:0] stage_idx_s;

  logic       in_ready_3, wr_en_3, wr_bank_3, stage_en_3, calc_bank_3, frame_done_3, ovf_3;
  logic [4:0] wr_addr_3;
  logic [15:0] wr_data_3;
  logic [2:0] stage_idx_3;

  fft_frame_ctrl u_dut (
    .clk2(clk2), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .wr_en_o(wr_en), .wr_bank_o(wr_bank), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .stage_en_o(stage_en), .stage_idx_o(stage_idx),
    .calc_bank_o(calc_bank), .frame_done_o(frame_done), .ovf_o(ovf)
  );

  fft_frame_ctrl #(.STAGE_CYC(20)) u_dut_s (
    .clk2(clk2), .rst(rst), .in_valid_i(in_valid_s), .in_data_i(in_data),
    .in_ready_o(in_ready_s), .wr_en_o(wr_en_s), .wr_bank_o(wr_bank_s), .wr_addr_o(wr_addr_s),
    .wr_data_o(wr_data_s), .stage_en_o(stage_en_s), .stage_idx_o(stage_idx_s),
    .calc_bank_o(calc_bank_s), .frame_done_o(frame_done_s), .ovf_o(ovf_s)
  );

  fft_frame_ctrl #(.STAGE_CYC(3)) u_dut_3 (
    .clk2(clk2), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_3), .wr_en_o(wr_en_3), .wr_bank_o(wr_bank_3), .wr_addr_o(wr_addr_3),
    .wr_data_o(wr_data_3), .stage_en_o(stage_en_3), .stage_idx_o(stage_idx_3),
    .calc_bank_o(calc_bank_3), .frame_done_o(frame_done_3), .ovf_o(ovf_3)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  int checks = 0;
  int errors = 0;

  logic [21:0] sb[$];
  logic        m_bank;
  logic [4:0]  m_cnt;

  // Per-instance stage model state: 0 = default, 1 = STAGE_CYC 20, 2 = STAGE_CYC 3.
  int   pos[3];
  logic ecb[3];
  int   nfd[3];
  int   en_tot[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stage_chk(input int n, input string tag, input logic en, input logic [2:0] idx,
                           input logic fd, input logic cb, input int cyc);
    if (en) begin
      chk({tag, "_idx"}, 32'(idx), 32'(pos[n] / cyc));
      pos[n]++;
      en_tot[n]++;
    end
    if (fd) begin
      chk({tag, "_len"}, 32'(pos[n]), 32'(5 * cyc));
      chk({tag, "_cbank"}, 32'(cb), 32'(ecb[n]));
      ecb[n] = ~ecb[n];
      pos[n] = 0;
      nfd[n]++;
    end
  endtask

  always @(negedge clk2) begin
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        pos[n] = 0;
        ecb[n] = 1'b0;
      end
    end else begin
      if (wr_en) begin
        if (sb.size() == 0) chk("extra_write", 32'(wr_addr), 32'hffff_ffff);
        else chk("wr_bank_addr_data", 32'({wr_bank, wr_addr, wr_data}), 32'(sb.pop_front()));
      end
      stage_chk(0, "st1", stage_en, stage_idx, frame_done, calc_bank, 1);
      stage_chk(1, "st20", stage_en_s, stage_idx_s, frame_done_s, calc_bank_s, 20);
      stage_chk(2, "st3", stage_en_3, stage_idx_3, frame_done_3, calc_bank_3, 3);
    end
  end

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  // Main instance never stalls in these phases, so every valid sample is expected to be written.
  task automatic drive(input logic vm, input logic vs, input logic [15:0] d);
    in_valid   = vm;
    in_valid_s = vs;
    in_data    = d;
    if (vm) begin
      sb.push_back({m_bank, m_cnt, d});
      if (m_cnt == 5'd31) begin
        m_cnt  = '0;
        m_bank = ~m_bank;
      end else begin
        m_cnt = m_cnt + 5'd1;
      end
    end
    step();
  endtask

  task automatic idle(input int n);
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
    rst        = 1'b1;
    sb.delete();
    m_cnt  = '0;
    m_bank = 1'b0;
    for (int n = 0; n < 3; n++) begin
      nfd[n]    = 0;
      en_tot[n] = 0;
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int acc;
    int k;
    in_data = '0;
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_stage_en", 32'(stage_en), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_banks", 32'({wr_bank, calc_bank}), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);

    // One frame, back-to-back samples, exact stage latency.
    for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 16'(i));
    in_valid = 1'b0;
    chk("t1_no_stage_yet", 32'(stage_en), 32'd0);
    chk("t1_wr_bank_toggled", 32'(wr_bank), 32'd1);
    for (int s = 0; s < 5; s++) begin
      step();
      chk("t1_stage_en", 32'(stage_en), 32'd1);
      chk("t1_stage_idx", 32'(stage_idx), 32'(s));
    end
    step();
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    chk("t1_stage_off", 32'(stage_en), 32'd0);
    step();
    chk("t1_done_pulse", 32'(frame_done), 32'd0);
    chk("t1_calc_bank", 32'(calc_bank), 32'd1);
    idle(20);
    chk("t1_nfd", 32'(nfd[0]), 32'd1);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_en_cycles", 32'(en_tot[2]), 32'd15);
    chk("t6_nfd", 32'(nfd[2]), 32'd1);

    // Continuous 96-sample stream: in_ready never drops.
    do_reset();
    for (int i = 0; i < 96; i++) begin
      drive(1'b1, 1'b0, 16'(i + 100));
      chk("t2_in_ready", 32'(in_ready), 32'd1);
    end
    idle(20);
    chk("t2_nfd", 32'(nfd[0]), 32'd3);
    chk("t2_nfd3", 32'(nfd[2]), 32'd3);
    chk("t2_ovf", 32'(ovf), 32'd0);
    chk("t2_calc_bank", 32'(calc_bank), 32'd1);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Random gaps in in_valid.
    do_reset();
    acc = 0;
    k   = 0;
    while (acc < 32 && k < 1000) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      drive(v, 1'b0, 16'(acc + 500));
      if (v) acc++;
      k++;
    end
    chk("t3_accepts", 32'(acc), 32'd32);
    chk("t3_wr_bank", 32'(wr_bank), 32'd1);
    idle(20);
    chk("t3_nfd", 32'(nfd[0]), 32'd1);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Stall the slow instance: both banks full, overflow, then release.
    do_reset();
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 16'(i));
    chk("t4_stalled", 32'(in_ready_s), 32'd0);
    chk("t4_ovf_before", 32'(ovf_s), 32'd0);
    step();
    chk("t4_ovf_set", 32'(ovf_s), 32'd1);
    k = 0;
    while (!frame_done_s && k < 300) begin
      step();
      k++;
    end
    chk("t4_frame_done_seen", 32'(frame_done_s), 32'd1);
    chk("t4_ready_during_done", 32'(in_ready_s), 32'd0);
    step();
    chk("t4_ready_after_done", 32'(in_ready_s), 32'd1);
    chk("t4_ovf_sticky", 32'(ovf_s), 32'd1);
    chk("t4_main_ovf", 32'(ovf), 32'd0);
    in_valid_s = 1'b0;

    // Asynchronous reset at sample 17 of frame 2 while the slow instance is in RUN.
    do_reset();
    for (int i = 0; i < 49; i++) drive(1'b1, 1'b1, 16'(i + 300));
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
    chk("t5_run_active", 32'(stage_en_s), 32'd1);
    chk("t5_mid_addr", 32'(wr_addr), 32'd17);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_stage_en", 32'(stage_en_s), 32'd0);
    chk("t5_rst_banks", 32'({wr_bank, calc_bank, wr_bank_s, calc_bank_s}), 32'd0);
    chk("t5_rst_addr", 32'(wr_addr), 32'd0);
    chk("t5_rst_ready", 32'(in_ready_s), 32'd1);
    chk("t5_rst_fd", 32'(frame_done_s), 32'd0);
    do_reset();
    for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 16'(i + 700));
    idle(40);
    chk("t5_nfd", 32'(nfd[0]), 32'd1);
    chk("t5_nfd_slow", 32'(nfd[1]), 32'd0);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Controller for the 32-point FFT front end. It accepts a serial sample stream with a valid/ready handshake and writes each frame into one of two 32-entry input register banks (ping-pong). When a bank holds a complete frame, the controller sequences the butterfly stages over that bank while the other bank fills. It sits between the sample source and the input register banks / butterfly datapath.

Parameters:
N, 16, sample width in bits (passed through unchanged)
NPTS, 32, points per frame; power of two
AW, 5, log2(NPTS); width of the write address
STAGES, 5, butterfly stages per frame; equals AW
STAGE_CYC, 1, clock cycles per butterfly stage; must be >= 1

Ports:
clk2  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  source has a sample on in_data
in_data  in  N  input sample
in_ready  out  1  controller can accept a sample this cycle
wr_en  out  1  write strobe to the input register banks
wr_bank  out  1  bank being filled (0/1)
wr_addr  out  AW  entry index within wr_bank
wr_data  out  N  data to write; equals in_data
stage_en  out  1  butterfly datapath enable
stage_idx  out  3  current stage, 0..STAGES-1
calc_bank  out  1  bank the datapath reads
frame_done  out  1  one-cycle pulse when a frame's last stage completes
ovf  out  1  sticky: in_valid asserted while in_ready low

Behaviour:
- Reset (async, rst=1): fill_cnt=0, wr_bank=0, calc_bank=0, full[1:0]=0, FSM=IDLE, stage_idx=0, cyc_cnt=0, stage_en=0, frame_done=0, ovf=0. in_ready=1 and wr_en=0 once rst deasserts (nothing ever full).
- Reset mid-frame discards partial and queued frames; no frame_done is issued for them.
- Fill side (combinational outputs):
  - in_ready = !full[wr_bank].
  - wr_en = in_valid & in_ready.
  - wr_addr = fill_cnt.
  - wr_data = in_data.
- Fill side (on accept, wr_en=1):
  - fill_cnt increments.
  - At fill_cnt==NPTS-1: fill_cnt wraps to 0, full[wr_bank] is set, wr_bank toggles.
- No accept: fill_cnt holds. Gaps in in_valid are allowed anywhere in a frame.
- ovf sets on any cycle with in_valid=1 and in_ready=0. It is cleared only by rst. The rejected sample is not written.
- Compute FSM (registered outputs):
  - IDLE: stage_en=0. If full[calc_bank]=1 -> RUN, with stage_idx=0 and cyc_cnt=0.
  - RUN: stage_en=1.
    - cyc_cnt counts 0..STAGE_CYC-1. At STAGE_CYC-1 it returns to 0 and stage_idx increments.
    - At the last cycle of stage STAGES-1 -> DONE.
  - DONE: stage_en=0, frame_done=1 for exactly one cycle, full[calc_bank] cleared, calc_bank toggles -> IDLE.
- Latency: the 32nd sample is accepted at edge t. stage_en is high from edge t+1 for STAGES*STAGE_CYC cycles. frame_done is high for one cycle after that. With defaults: stage_en high during cycles t+1..t+5, frame_done high at t+6.
- Back-to-back frames: IDLE re-enters RUN on the cycle after DONE if the other bank is already full. This gives one idle cycle between frames.
- Simultaneous set/clear of full[]: fill sets only a non-full bank and compute clears only a full bank, so the two always target different bits. Both updates take effect in the same cycle.
- Both banks full: in_ready=0 until DONE clears one bank. in_ready rises the cycle after frame_done.
- stage_idx holds its last value outside RUN; it is only meaningful while stage_en=1.

Test Plan:
- Reset then stream 32 samples 0..31 back-to-back -> wr_addr 0..31 on bank 0; wr_data matches; stage_en high 5 cycles from the cycle after the 32nd accept, stage_idx 0,1,2,3,4; frame_done one pulse; calc_bank becomes 1.
- Continuous stream of 96 samples -> banks fill 0,1,0; three frame_done pulses; in_ready never drops (compute takes 6 cycles, which is less than the 32-cycle fill); ovf=0.
- Stall the FSM with STAGE_CYC=20: stream 64 samples then keep in_valid=1 -> in_ready=0 after sample 64; ovf=1; in_ready returns the cycle after frame_done; ovf stays 1.
- Random in_valid gaps (50% duty) over 32 samples -> wr_addr increments only on accepts; frame completes at the 32nd accept; no extra writes.
- Assert rst at sample 17 of frame 2 while RUN is active -> all outputs return to reset values immediately; the next 32 samples land in bank 0 at addresses 0..31.
- STAGE_CYC=3 -> each stage_idx value is held for 3 cycles; stage_en is high for 15 cycles in total.
